cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Result-bus (CDB) arbiter and holding stage for the out-of-order pipeline. It collects completed results from NUM_REQ functional units (ALU, load/store, mul/div, ...), each through a one-entry holding register, and grants the single common data bus round-robin. The winning result is broadcast, registered, to the reservation stations and ROB. Units are back-pressured through a valid/ready handshake instead of a stall pair, and a flush drops all in-flight results.

## Interface
Parameters:
- NUM_REQ, 3, number of functional-unit requesters (2..8); index 0 = ALU, 1 = load/store.
- DATA_W, 32, result data width.
- TAG_W, 6, ROB/physical-register tag width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous squash of all buffered and outgoing results.
- req_valid  input  NUM_REQ  per-unit result valid.
- req_tag  input  NUM_REQ*TAG_W  per-unit tag; slice i = bits [i*TAG_W +: TAG_W].
- req_data  input  NUM_REQ*DATA_W  per-unit data; same slicing.
- req_ready  output  NUM_REQ  per-unit accept.
- cdb_valid  output  1  broadcast valid (registered).
- cdb_tag  output  TAG_W  broadcast tag (registered).
- cdb_data  output  DATA_W  broadcast data (registered).
- cdb_src  output  $clog2(NUM_REQ)  index of the winning unit (registered).
- conflict_cnt  output  16  saturating count of cycles with two or more holding registers valid.

## Operation
- Per unit i: holding register hold_v[i] / hold_tag[i] / hold_data[i].
- Accept: req_valid[i] && req_ready[i] at a rising edge loads the holding register and sets hold_v[i].
- req_ready[i] = ~flush && (~hold_v[i] || gnt[i]). This allows back-to-back acceptance when the held entry drains in the same cycle. req_ready does not depend on req_valid.
- Arbitration is combinational over hold_v only; incoming requests are not eligible in their accept cycle.
  - Search starts at rr_ptr and proceeds upward, wrapping modulo NUM_REQ.
  - The first set hold_v wins; gnt is one-hot or zero.
- On grant to w:
  - The broadcast registers load hold_tag[w], hold_data[w] and src = w, with cdb_valid = 1.
  - hold_v[w] clears unless a new accept on w occurs in the same edge; the new accept has priority and leaves hold_v[w] set with the new data.
  - rr_ptr becomes w+1, or 0 if w = NUM_REQ-1.
- No grant: cdb_valid becomes 0 and rr_ptr holds. cdb_tag, cdb_data and cdb_src hold their last values.
- Flush (checked at the edge):
  - Clears all hold_v and clears cdb_valid. No grant takes effect and no accept occurs.
  - rr_ptr and conflict_cnt are unchanged.
- conflict_cnt increments by 1 each cycle where popcount(hold_v) >= 2 and flush = 0. It saturates at 16'hFFFF.
- Reset (rst low, asynchronous): hold_v = 0, all holding data = 0, cdb_valid = 0, cdb_tag = 0, cdb_data = 0, cdb_src = 0, rr_ptr = 0, conflict_cnt = 0.
- Reset effect on req_ready: while in reset, req_ready is all-ones except when flush is high.

## Timing
- Minimum latency is 2 edges: req_valid presented in cycle 0 and accepted at edge 1; granted in cycle 1; cdb_valid high in cycle 2.
- Throughput: one broadcast per cycle total. Each unit sustains one result per cycle only while it wins every cycle.
- Fairness: under constant contention, each requester is granted at least once every NUM_REQ cycles.
- A unit holding valid data with req_ready low must keep req_valid, req_tag and req_data stable.
- Flush asserted in the same cycle as req_valid: the result is dropped, req_ready = 0, and it never appears on the CDB.
- Reset deasserted mid-stream: no stale broadcast; the first cdb_valid occurs at least 2 edges after the first accept.

## Test plan
- Single ALU result, tag 6'h05, data 32'hDEAD_BEEF in cycle 0 -> cdb_valid = 1, cdb_tag = 5, cdb_data = DEADBEEF, cdb_src = 0 in cycle 2 only.
- ALU and LS valid every cycle for 10 cycles (NUM_REQ = 3) -> cdb_src alternates 0,1,0,1,...; each unit accepted 5 times ±1; conflict_cnt counts each cycle with both hold_v set; no result lost or duplicated (tag scoreboard).
- All 3 units continuously valid -> grant order 0,1,2,0,1,2; req_ready[i] high only in cycles where i is granted.
- Flush while all holding registers are full and cdb_valid = 1 -> next cycle cdb_valid = 0, hold_v = 0; an offered request in the flush cycle is never broadcast; rr_ptr is unchanged.
- Assert rst low asynchronously between edges while cdb_valid = 1 -> cdb_valid, cdb_src and conflict_cnt read 0 immediately; after release, the first broadcast follows a fresh accept by 2 edges.
- Force conflict_cnt to 16'hFFFE, then hold contention for 3 cycles -> the count stops at 16'hFFFF.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-unit one-entry holding registers feeding a single
// round-robin arbitrated, registered common data bus broadcast.
//
// Handshake: a unit presents req_valid with req_tag/req_data; the result
// transfers on a rising edge where req_valid && req_ready. req_ready never
// depends on req_valid. While req_valid is high and req_ready low the unit
// keeps req_valid, req_tag and req_data stable. cdb_valid is a one-cycle
// broadcast strobe with no back-pressure from the consumers.
module cdb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]     req_tag,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         cdb_valid,
  output logic [TAG_W-1:0]             cdb_tag,
  output logic [DATA_W-1:0]            cdb_data,
  output logic [$clog2(NUM_REQ)-1:0]   cdb_src,
  output logic [15:0]                  conflict_cnt
);

  localparam int SRC_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] hold_v;
  logic [TAG_W-1:0]   hold_tag  [NUM_REQ];
  logic [DATA_W-1:0]  hold_data [NUM_REQ];
  logic [SRC_W-1:0]   rr_ptr;
  logic [SRC_W-1:0]   ptr_next;
  logic [NUM_REQ-1:0] gnt;
  logic [SRC_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic [NUM_REQ-1:0] accept;
  logic               multi_valid;

  // Index base+k wrapped modulo NUM_REQ (k is always below NUM_REQ).
  function automatic logic [SRC_W-1:0] wrap_idx(input logic [SRC_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return SRC_W'(s);
  endfunction

  // Round-robin search over held entries only, starting at rr_ptr.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt_any && hold_v[wrap_idx(rr_ptr, k)]) begin
        gnt_any                   = 1'b1;
        gnt_idx                   = wrap_idx(rr_ptr, k);
        gnt[wrap_idx(rr_ptr, k)]  = 1'b1;
      end
    end
  end

  // A unit may hand over a new result when its slot is empty or draining now.
  assign req_ready   = {NUM_REQ{~flush}} & (~hold_v | gnt);
  assign accept      = req_valid & req_ready;
  assign multi_valid = ($countones(hold_v) >= 2);
  assign ptr_next    = (gnt_idx == SRC_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  // Holding registers: a same-edge accept overrides the drain of a granted entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_v <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        hold_tag[i]  <= '0;
        hold_data[i] <= '0;
      end
    end else if (flush) begin
      hold_v <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept[i]) begin
          hold_v[i]    <= 1'b1;
          hold_tag[i]  <= req_tag[i*TAG_W +: TAG_W];
          hold_data[i] <= req_data[i*DATA_W +: DATA_W];
        end else if (gnt[i]) begin
          hold_v[i] <= 1'b0;
        end
      end
    end
  end

  // Registered broadcast and round-robin pointer; payload holds when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_src   <= '0;
      rr_ptr    <= '0;
    end else if (flush) begin
      cdb_valid <= 1'b0;
    end else if (gnt_any) begin
      cdb_valid <= 1'b1;
      cdb_tag   <= hold_tag[gnt_idx];
      cdb_data  <= hold_data[gnt_idx];
      cdb_src   <= gnt_idx;
      rr_ptr    <= ptr_next;
    end else begin
      cdb_valid <= 1'b0;
    end
  end

  // Saturating count of cycles where two or more units compete for the bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflict_cnt <= '0;
    end else if (!flush && multi_valid && conflict_cnt != 16'hFFFF) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed vector table plus randomized traffic checked
// against a behavioural model of the result bus arbiter.
module tb_cdb_arbiter;

  localparam int NUM_REQ = 3;
  localparam int DATA_W  = 32;
  localparam int TAG_W   = 6;
  localparam int SRC_W   = 2;
  localparam int QW      = SRC_W + TAG_W + DATA_W;

  logic                      clk = 1'b0;
  logic                      rst = 1'b0;
  logic                      flush = 1'b0;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ*TAG_W-1:0]  req_tag = '0;
  logic [NUM_REQ*DATA_W-1:0] req_data = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      cdb_valid;
  logic [TAG_W-1:0]          cdb_tag;
  logic [DATA_W-1:0]         cdb_data;
  logic [SRC_W-1:0]          cdb_src;
  logic [15:0]               conflict_cnt;

  cdb_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_tag(req_tag), .req_data(req_data),
    .req_ready(req_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .cdb_src(cdb_src), .conflict_cnt(conflict_cnt)
  );

  // Clock
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_data(input logic [5:0] t);
    return 32'hDEADBEEA + 32'(t);
  endfunction

  // Behavioural model state: one slot per unit, pointer, counter, last source.
  bit               m_v    [NUM_REQ];
  logic [5:0]       m_tag  [NUM_REQ];
  logic [31:0]      m_data [NUM_REQ];
  int               m_ptr;
  int               m_cnt;
  logic [SRC_W-1:0] m_src;
  logic [QW-1:0]    exp_q[$];

  task automatic model_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      m_v[i] = 0; m_tag[i] = '0; m_data[i] = '0;
    end
    m_ptr = 0; m_cnt = 0; m_src = '0;
    exp_q.delete();
  endtask

  function automatic int model_winner();
    for (int k = 0; k < NUM_REQ; k++)
      if (m_v[(m_ptr + k) % NUM_REQ]) return (m_ptr + k) % NUM_REQ;
    return -1;
  endfunction

  // Reset: checks the reset state while rst is low, releases at the next negedge.
  task automatic do_reset();
    rst = 1'b0; flush = 1'b0; req_valid = '0;
    #1;
    check("rst_cdb_valid", cdb_valid, 1'b0);
    check("rst_cdb_src", cdb_src, '0);
    check("rst_conflict", conflict_cnt, '0);
    check("rst_ready", req_ready, 3'b111);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One model cycle: inputs already driven just after a negedge.
  task automatic model_cycle(output logic [NUM_REQ-1:0] acc, output logic cv);
    int w, pc;
    logic [NUM_REQ-1:0] r;
    logic [QW-1:0] e;
    #1;
    w = model_winner();
    for (int i = 0; i < NUM_REQ; i++) r[i] = !flush && (!m_v[i] || w == i);
    check("req_ready", req_ready, r);
    acc = r & req_valid;
    @(posedge clk);
    pc = 0;
    for (int i = 0; i < NUM_REQ; i++) pc += int'(m_v[i]);
    if (!flush && pc >= 2 && m_cnt < 65535) m_cnt++;
    if (flush) begin
      for (int i = 0; i < NUM_REQ; i++) m_v[i] = 0;
    end else begin
      if (w >= 0) begin
        exp_q.push_back({2'(w), m_tag[w], m_data[w]});
        m_v[w] = 0;
        m_ptr  = (w + 1) % NUM_REQ;
        m_src  = 2'(w);
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc[i]) begin
          m_v[i]    = 1;
          m_tag[i]  = req_tag[i*TAG_W +: TAG_W];
          m_data[i] = req_data[i*DATA_W +: DATA_W];
        end
      end
    end
    @(negedge clk);
    cv = 1'b0;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      cv = 1'b1;
      check("cdb_valid", cdb_valid, 1'b1);
      check("cdb_tag", cdb_tag, e[DATA_W +: TAG_W]);
      check("cdb_data", cdb_data, e[DATA_W-1:0]);
    end else begin
      check("cdb_valid_idle", cdb_valid, 1'b0);
    end
    check("cdb_src", cdb_src, m_src);
    check("conflict_cnt", conflict_cnt, m_cnt);
  endtask

  // Directed vector table
  typedef struct {
    logic        rb;
    logic        fl;
    logic [2:0]  v;
    logic [17:0] tags;
    logic [2:0]  rdy;
    logic        cv;
    logic [5:0]  ctag;
    logic [1:0]  src;
    int          cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rb, input logic fl, input logic [2:0] v, input logic [17:0] tags,
                     input logic [2:0] rdy, input logic cv, input logic [5:0] ctag,
                     input logic [1:0] src, input int cnt);
    tbl.push_back('{rb, fl, v, tags, rdy, cv, ctag, src, cnt});
  endtask

  // Unit driver state for random traffic
  bit         pend [NUM_REQ];
  logic [3:0] seq  [NUM_REQ];

  task automatic drive_units(input int pct, input int flush_pct);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pend[i]) begin
        if ($urandom_range(0, 99) < pct) begin
          pend[i] = 1;
          seq[i]  = seq[i] + 4'd1;
          req_valid[i] = 1'b1;
          req_tag[i*TAG_W +: TAG_W] = {2'(i), seq[i]};
          req_data[i*DATA_W +: DATA_W] = $urandom;
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
    flush = ($urandom_range(0, 99) < flush_pct);
  endtask

  task automatic retire_units(input logic [NUM_REQ-1:0] acc);
    for (int i = 0; i < NUM_REQ; i++)
      if (acc[i] || flush) pend[i] = 0;
  endtask

  initial begin
    logic [NUM_REQ-1:0] acc;
    logic cv;
    bit did_mid_rst;

    // Single ALU result, then three-way contention, flush and pointer retention.
    add(1, 0, 3'b001, {6'h00, 6'h00, 6'h05}, 3'b111, 0, 6'h00, 2'd0, 0);
    add(0, 0, 3'b000, {6'h00, 6'h00, 6'h05}, 3'b111, 1, 6'h05, 2'd0, 0);
    add(0, 0, 3'b000, {6'h00, 6'h00, 6'h05}, 3'b111, 0, 6'h00, 2'd0, 0);
    add(1, 0, 3'b111, {6'h20, 6'h10, 6'h00}, 3'b111, 0, 6'h00, 2'd0, 0);
    add(0, 0, 3'b111, {6'h21, 6'h11, 6'h01}, 3'b001, 1, 6'h00, 2'd0, 1);
    add(0, 0, 3'b111, {6'h21, 6'h11, 6'h02}, 3'b010, 1, 6'h10, 2'd1, 2);
    add(0, 0, 3'b111, {6'h21, 6'h12, 6'h02}, 3'b100, 1, 6'h20, 2'd2, 3);
    add(0, 0, 3'b111, {6'h22, 6'h12, 6'h02}, 3'b001, 1, 6'h01, 2'd0, 4);
    add(0, 1, 3'b111, {6'h22, 6'h12, 6'h03}, 3'b000, 0, 6'h00, 2'd0, 4);
    add(0, 0, 3'b000, {6'h22, 6'h12, 6'h03}, 3'b111, 0, 6'h00, 2'd0, 4);
    add(0, 0, 3'b101, {6'h25, 6'h00, 6'h05}, 3'b111, 0, 6'h00, 2'd0, 4);
    add(0, 0, 3'b000, {6'h25, 6'h00, 6'h05}, 3'b110, 1, 6'h25, 2'd2, 5);
    add(0, 0, 3'b000, {6'h25, 6'h00, 6'h05}, 3'b111, 1, 6'h05, 2'd0, 5);
    add(0, 0, 3'b000, {6'h25, 6'h00, 6'h05}, 3'b111, 0, 6'h00, 2'd0, 5);

    for (int n = 0; n < tbl.size(); n++) begin
      if (tbl[n].rb) do_reset();
      flush     = tbl[n].fl;
      req_valid = tbl[n].v;
      req_tag   = tbl[n].tags;
      for (int i = 0; i < NUM_REQ; i++)
        req_data[i*DATA_W +: DATA_W] = mk_data(tbl[n].tags[i*TAG_W +: TAG_W]);
      #1;
      check($sformatf("vec%0d_ready", n), req_ready, tbl[n].rdy);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d_cdb_valid", n), cdb_valid, tbl[n].cv);
      if (tbl[n].cv) begin
        check($sformatf("vec%0d_cdb_tag", n), cdb_tag, tbl[n].ctag);
        check($sformatf("vec%0d_cdb_data", n), cdb_data, mk_data(tbl[n].ctag));
      end
      check($sformatf("vec%0d_cdb_src", n), cdb_src, tbl[n].src);
      check($sformatf("vec%0d_conflict", n), conflict_cnt, tbl[n].cnt);
    end

    // Randomized traffic with flushes and one asynchronous mid-cycle reset.
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin pend[i] = 0; seq[i] = '0; end
    did_mid_rst = 0;
    for (int c = 0; c < 600; c++) begin
      drive_units(60, 4);
      model_cycle(acc, cv);
      retire_units(acc);
      if (c >= 200 && !did_mid_rst && cv) begin
        did_mid_rst = 1;
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_cdb_valid", cdb_valid, 1'b0);
        check("async_rst_cdb_src", cdb_src, '0);
        check("async_rst_conflict", conflict_cnt, '0);
        check("async_rst_ready", req_ready, {NUM_REQ{~flush}});
        model_reset();
        for (int i = 0; i < NUM_REQ; i++) pend[i] = 0;
        @(negedge clk);
        rst = 1'b1;
      end
    end
    check("mid_reset_hit", did_mid_rst, 1'b1);

    // Sustained full contention drives the conflict counter into saturation.
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) pend[i] = 0;
    for (int c = 0; c < 65540; c++) begin
      drive_units(100, 0);
      model_cycle(acc, cv);
      retire_units(acc);
    end
    check("conflict_saturated", conflict_cnt, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
